// File: rtl/hilo_muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide/move sequencer.
//   HiloDataW    : default operand / HI / LO width
//   hilo_op_e    : HI/LO writer op codes carried on op_i
//   hilo_state_e : controller FSM states
package hilo_muldiv_ctrl_pkg;

   localparam int unsigned HiloDataW = 32;

   typedef enum logic [2:0] {
      OpMult  = 3'd0,
      OpMultu = 3'd1,
      OpDiv   = 3'd2,
      OpDivu  = 3'd3,
      OpMthi  = 3'd4,
      OpMtlo  = 3'd5
   } hilo_op_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2,
      StDone = 2'd3
   } hilo_state_e;

   // Signed flavours of MULT/DIV.
   function automatic logic op_is_signed(logic [2:0] op);
      return (op == OpMult) || (op == OpDiv);
   endfunction

endpackage

// File: rtl/hilo_muldiv_ctrl_div_core.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : load operands and begin (pulse)
//   abort             : drop the running division
//   is_signed         : operands are two's complement
//   opa, opb          : dividend, divisor (divisor must be non-zero)
//   busy              : division in progress
//   done              : final step is being taken this cycle
//   quot, rem         : sign-corrected results, valid while done is high
module hilo_muldiv_ctrl_div_core
   import hilo_muldiv_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = HiloDataW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              is_signed,
   input  logic [DATA_W-1:0] opa,
   input  logic [DATA_W-1:0] opb,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] quot,
   output logic [DATA_W-1:0] rem
);

   localparam int unsigned CntW = $clog2(DATA_W);

   logic              busy_q;
   logic [CntW-1:0]   count_q;
   logic [DATA_W-1:0] rem_q;
   logic [DATA_W-1:0] quot_q;      // dividend shifts out the top, quotient in the bottom
   logic [DATA_W-1:0] divisor_q;
   logic              neg_q_q;
   logic              neg_r_q;

   logic              a_neg;
   logic              b_neg;
   logic [DATA_W-1:0] a_mag;
   logic [DATA_W-1:0] b_mag;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] rem_step;
   logic [DATA_W-1:0] quot_step;

   always_comb begin
      a_neg   = is_signed & opa[DATA_W-1];
      b_neg   = is_signed & opb[DATA_W-1];
      a_mag   = a_neg ? -opa : opa;
      b_mag   = b_neg ? -opb : opb;

      shifted = {rem_q, quot_q[DATA_W-1]};
      diff    = shifted - {1'b0, divisor_q};
      // Borrow out means the trial subtraction failed: restore.
      if (!diff[DATA_W]) begin
         rem_step  = diff[DATA_W-1:0];
         quot_step = {quot_q[DATA_W-2:0], 1'b1};
      end else begin
         rem_step  = shifted[DATA_W-1:0];
         quot_step = {quot_q[DATA_W-2:0], 1'b0};
      end

      busy = busy_q;
      done = busy_q & (count_q == CntW'(DATA_W - 1));
      // Results are taken from the step outputs so the controller can latch them
      // on the same edge that retires the final step.
      quot = neg_q_q ? -quot_step : quot_step;
      rem  = neg_r_q ? -rem_step : rem_step;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_q    <= 1'b0;
         count_q   <= '0;
         rem_q     <= '0;
         quot_q    <= '0;
         divisor_q <= '0;
         neg_q_q   <= 1'b0;
         neg_r_q   <= 1'b0;
      end else if (abort) begin
         busy_q  <= 1'b0;
         count_q <= '0;
      end else if (start) begin
         busy_q    <= 1'b1;
         count_q   <= '0;
         rem_q     <= '0;
         quot_q    <= a_mag;
         divisor_q <= b_mag;
         neg_q_q   <= a_neg ^ b_neg;
         neg_r_q   <= a_neg;
      end else if (busy_q) begin
         rem_q   <= rem_step;
         quot_q  <= quot_step;
         count_q <= count_q + CntW'(1);
         if (done) begin
            busy_q <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO writer sequencer: MULT/MULTU, DIV/DIVU and MTHI/MTLO.
// Stalls EX while an op runs, then pulses one HI/LO write.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start_i, op_i     : EX holds a HI/LO op (held until stall_o is low)
//   opa_i, opb_i      : rs / rt values
//   hi_i, lo_i        : current HI / LO (the half MTxx keeps)
//   annul_i           : flush, abort any op without writing
//   stall_o           : combinational pipeline stall request
//   hilo_we_o         : one-cycle HI/LO write enable
//   hi_o, lo_o        : HI / LO write data, held between writes
module hilo_muldiv_ctrl
   import hilo_muldiv_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = HiloDataW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_i,
   input  logic [2:0]        op_i,
   input  logic [DATA_W-1:0] opa_i,
   input  logic [DATA_W-1:0] opb_i,
   input  logic [DATA_W-1:0] hi_i,
   input  logic [DATA_W-1:0] lo_i,
   input  logic              annul_i,
   output logic              stall_o,
   output logic              hilo_we_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   hilo_state_e       state_q, state_d;
   logic [DATA_W-1:0] hi_q, hi_d;
   logic [DATA_W-1:0] lo_q, lo_d;
   logic [DATA_W-1:0] opa_q, opa_d;
   logic [DATA_W-1:0] opb_q, opb_d;
   logic              mul_signed_q, mul_signed_d;

   logic [2*DATA_W-1:0] mul_a;
   logic [2*DATA_W-1:0] mul_b;
   logic [2*DATA_W-1:0] prod;

   logic              div_start;
   logic              div_busy;
   logic              div_done;
   logic [DATA_W-1:0] div_quot;
   logic [DATA_W-1:0] div_rem;

   // Extending both operands to 2*DATA_W makes the low half of a plain
   // multiply correct for both signed and unsigned products.
   always_comb begin
      mul_a = {{DATA_W{mul_signed_q & opa_q[DATA_W-1]}}, opa_q};
      mul_b = {{DATA_W{mul_signed_q & opb_q[DATA_W-1]}}, opb_q};
      prod  = mul_a * mul_b;
   end

   hilo_muldiv_ctrl_div_core #(
      .DATA_W (DATA_W)
   ) u_div_core (
      .clk       (clk),
      .rst       (rst),
      .start     (div_start),
      .abort     (annul_i),
      .is_signed (op_is_signed(op_i)),
      .opa       (opa_i),
      .opb       (opb_i),
      .busy      (div_busy),
      .done      (div_done),
      .quot      (div_quot),
      .rem       (div_rem)
   );

   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      lo_d         = lo_q;
      opa_d        = opa_q;
      opb_d        = opb_q;
      mul_signed_d = mul_signed_q;
      div_start    = 1'b0;
      stall_o      = 1'b0;
      hilo_we_o    = 1'b0;

      if (rst) begin
         state_d = StIdle;
      end else if (annul_i) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  case (op_i)
                     OpMult, OpMultu: begin
                        stall_o      = 1'b1;
                        opa_d        = opa_i;
                        opb_d        = opb_i;
                        mul_signed_d = op_is_signed(op_i);
                        state_d      = StMul;
                     end
                     OpDiv, OpDivu: begin
                        stall_o = 1'b1;
                        if (opb_i == '0) begin
                           // Divide by zero: no trap, fixed result.
                           hi_d    = opa_i;
                           lo_d    = '1;
                           state_d = StDone;
                        end else begin
                           div_start = 1'b1;
                           state_d   = StDiv;
                        end
                     end
                     OpMthi: begin
                        hi_d    = opa_i;
                        lo_d    = lo_i;
                        state_d = StDone;
                     end
                     OpMtlo: begin
                        hi_d    = hi_i;
                        lo_d    = opa_i;
                        state_d = StDone;
                     end
                     default: ;
                  endcase
               end
            end
            StMul: begin
               stall_o = 1'b1;
               hi_d    = prod[2*DATA_W-1:DATA_W];
               lo_d    = prod[DATA_W-1:0];
               state_d = StDone;
            end
            StDiv: begin
               stall_o = 1'b1;
               if (div_done) begin
                  hi_d    = div_rem;
                  lo_d    = div_quot;
                  state_d = StDone;
               end else if (!div_busy) begin
                  state_d = StIdle;
               end
            end
            StDone: begin
               // Stall is low here so the op retires with its write; a start_i
               // still high in this cycle belongs to the same op.
               hilo_we_o = 1'b1;
               state_d   = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StIdle;
         hi_q         <= '0;
         lo_q         <= '0;
         opa_q        <= '0;
         opb_q        <= '0;
         mul_signed_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         hi_q         <= hi_d;
         lo_q         <= lo_d;
         opa_q        <= opa_d;
         opb_q        <= opb_d;
         mul_signed_q <= mul_signed_d;
      end
   end

   assign hi_o = hi_q;
   assign lo_o = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: multiply, divide, divide by zero,
// MTHI/MTLO, annul, mid-op reset and back-to-back ops.
module tb_hilo_muldiv_ctrl;
   import hilo_muldiv_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] opa_i;
   logic [31:0] opb_i;
   logic [31:0] hi_i;
   logic [31:0] lo_i;
   logic        annul_i;
   logic        stall_o;
   logic        hilo_we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int total = 0;
   int bad   = 0;

   hilo_muldiv_ctrl #(
      .DATA_W (32)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .op_i      (op_i),
      .opa_i     (opa_i),
      .opb_i     (opb_i),
      .hi_i      (hi_i),
      .lo_i      (lo_i),
      .annul_i   (annul_i),
      .stall_o   (stall_o),
      .hilo_we_o (hilo_we_o),
      .hi_o      (hi_o),
      .lo_o      (lo_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp)
      else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Issue one op at the current cycle (cycle 0 = acceptance) and follow it:
   // start_i drops after the first cycle with stall_o low, as the pipeline would.
   task automatic run_op(input string tag, input hilo_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hin, input logic [31:0] lin,
                         input int exp_stalls, input int exp_we_at,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int          stalls = 0;
      int          wes    = 0;
      int          we_at  = -1;
      logic [31:0] got_hi = '0;
      logic [31:0] got_lo = '0;
      bit          retired = 1'b0;
      bit          s;
      op_i    = op;
      opa_i   = a;
      opb_i   = b;
      hi_i    = hin;
      lo_i    = lin;
      start_i = 1'b1;
      for (int c = 0; c < 45; c++) begin
         #1;
         s = stall_o;
         if (s) stalls++;
         if (hilo_we_o) begin
            wes++;
            if (we_at < 0) begin
               we_at  = c;
               got_hi = hi_o;
               got_lo = lo_o;
            end
         end
         cyc();
         if (!s && !retired) begin
            retired = 1'b1;
            start_i = 1'b0;
         end
         if (we_at >= 0 && c >= we_at + 3) break;
      end
      start_i = 1'b0;
      check({tag, "_we_count"}, wes, 1);
      check({tag, "_we_cycle"}, we_at, exp_we_at);
      check({tag, "_stalls"}, stalls, exp_stalls);
      check({tag, "_hi"}, got_hi, exp_hi);
      check({tag, "_lo"}, got_lo, exp_lo);
   endtask

   initial begin
      int          wes;
      int          ph;
      int          we1_at;
      int          we2_at;
      logic [31:0] h1, l1, h2, l2;
      bit          s;

      rst     = 1'b1;
      start_i = 1'b0;
      op_i    = OpMult;
      opa_i   = '0;
      opb_i   = '0;
      hi_i    = '0;
      lo_i    = '0;
      annul_i = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
      #1;
      check("reset_stall", stall_o, 0);
      check("reset_we", hilo_we_o, 0);
      check("reset_hi", hi_o, 0);
      check("reset_lo", lo_o, 0);
      cyc();

      run_op("mult", OpMult, 32'hFFFF_FFFE, 32'h3, 0, 0, 2, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2, 2,
             32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'h2, 0, 0, 33, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu", OpDivu, 32'h7, 32'h2, 0, 0, 33, 33, 32'h1, 32'h3);
      run_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 33, 33, 32'h0, 32'h8000_0000);
      run_op("div_negb", OpDiv, 32'h7, 32'hFFFF_FFFE, 0, 0, 33, 33, 32'h1, 32'hFFFF_FFFD);
      run_op("divu_big", OpDivu, 32'hFFFF_FFFF, 32'hA, 0, 0, 33, 33, 32'h5, 32'h1999_9999);
      run_op("div_zero", OpDivu, 32'h5, 32'h0, 0, 0, 1, 1, 32'h5, 32'hFFFF_FFFF);
      run_op("mthi", OpMthi, 32'h1234, 32'h0, 32'h5555, 32'hABCD, 0, 1, 32'h1234, 32'hABCD);
      run_op("mtlo", OpMtlo, 32'h77, 32'h0, 32'h99, 32'h4444, 0, 1, 32'h99, 32'h77);

      // Annul a DIV in its tenth cycle.
      wes     = 0;
      op_i    = OpDiv;
      opa_i   = 32'd100;
      opb_i   = 32'd7;
      start_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (hilo_we_o) wes++;
         if (c == 9) check("annul_pre_stall", stall_o, 1);
         cyc();
      end
      annul_i = 1'b1;
      #1;
      check("annul_stall", stall_o, 0);
      if (hilo_we_o) wes++;
      cyc();
      annul_i = 1'b0;
      start_i = 1'b0;
      check("annul_no_we", wes, 0);
      run_op("after_annul", OpMultu, 32'h0001_0000, 32'h0001_0000, 0, 0, 2, 2, 32'h1, 32'h0);

      // Reset in the fifth cycle of a DIV with start_i held.
      wes     = 0;
      op_i    = OpDiv;
      opa_i   = 32'd100;
      opb_i   = 32'd7;
      start_i = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         if (hilo_we_o) wes++;
         cyc();
      end
      rst = 1'b1;
      #1;
      if (hilo_we_o) wes++;
      cyc();
      rst = 1'b0;
      #1;
      check("rst_no_we", wes, 0);
      check("rst_we_now", hilo_we_o, 0);
      check("rst_hi", hi_o, 0);
      check("rst_lo", lo_o, 0);
      run_op("rst_restart", OpDiv, 32'd100, 32'd7, 0, 0, 33, 33, 32'd2, 32'd14);

      // DIV then MULT back to back, start_i never dropping between them.
      wes     = 0;
      ph      = 0;
      we1_at  = -1;
      we2_at  = -1;
      h1 = '0; l1 = '0; h2 = '0; l2 = '0;
      op_i    = OpDiv;
      opa_i   = 32'd20;
      opb_i   = 32'd3;
      start_i = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #1;
         s = stall_o;
         if (hilo_we_o) begin
            wes++;
            if (we1_at < 0) begin
               we1_at = c; h1 = hi_o; l1 = lo_o;
            end else if (we2_at < 0) begin
               we2_at = c; h2 = hi_o; l2 = lo_o;
            end
         end
         cyc();
         if (!s && ph == 0) begin
            ph    = 1;
            op_i  = OpMult;
            opa_i = 32'hFFFF_FFFD;
            opb_i = 32'd5;
         end else if (!s && ph == 1) begin
            ph      = 2;
            start_i = 1'b0;
         end
      end
      check("b2b_we_count", wes, 2);
      check("b2b_div_at", we1_at, 33);
      check("b2b_div_hi", h1, 32'd2);
      check("b2b_div_lo", l1, 32'd6);
      check("b2b_mul_at", we2_at, 36);
      check("b2b_mul_hi", h2, 32'hFFFF_FFFF);
      check("b2b_mul_lo", l2, 32'hFFFF_FFF1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
